// File: rtl/mem_seq_arbiter_if.sv
// Bundles the fetch port, the data port and the 16-bit memory pins into one bus.
// The arbiter uses the slave modport; the requesters and the memory sit on the master side.
interface mem_seq_arbiter_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  instr_req_i;
    logic [ADDR_WIDTH-1:0] instr_addr_i;
    logic                  instr_gnt_o;
    logic                  instr_valid_o;
    logic [15:0]           instr_data_o;
    logic                  data_req_i;
    logic                  data_we_i;
    logic                  data_wide_i;
    logic [ADDR_WIDTH-1:0] data_addr_i;
    logic [31:0]           data_wdata_i;
    logic                  data_gnt_o;
    logic                  data_valid_o;
    logic [31:0]           data_rdata_o;
    logic                  busy_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [15:0]           mem_value_o;
    logic [15:0]           mem_value_i;
    logic                  mem_rd_en_o;
    logic                  mem_wr_en_o;
    logic                  mem_enable_o;

    modport slave (
        input  instr_req_i, instr_addr_i,
        input  data_req_i, data_we_i, data_wide_i, data_addr_i, data_wdata_i,
        input  mem_value_i,
        output instr_gnt_o, instr_valid_o, instr_data_o,
        output data_gnt_o, data_valid_o, data_rdata_o, busy_o,
        output mem_addr_o, mem_value_o, mem_rd_en_o, mem_wr_en_o, mem_enable_o
    );

    modport master (
        output instr_req_i, instr_addr_i,
        output data_req_i, data_we_i, data_wide_i, data_addr_i, data_wdata_i,
        output mem_value_i,
        input  instr_gnt_o, instr_valid_o, instr_data_o,
        input  data_gnt_o, data_valid_o, data_rdata_o, busy_o,
        input  mem_addr_o, mem_value_o, mem_rd_en_o, mem_wr_en_o, mem_enable_o
    );
endinterface

// File: rtl/mem_seq_arbiter.sv
// Shares one 16-bit memory port between fetch and data; 32-bit accesses split hi-then-lo.
// Latency: read 2 (wide 3), write 1 (wide 2); requests wait (held level) until their gnt pulse.
module mem_seq_arbiter #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_PRIO    = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    mem_seq_arbiter_if.slave bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_A    = 3'd1;
    localparam logic [2:0] S_RD_B    = 3'd2;
    localparam logic [2:0] S_RD_WAIT = 3'd3;
    localparam logic [2:0] S_WR_A    = 3'd4;
    localparam logic [2:0] S_WR_B    = 3'd5;

    localparam logic OWN_INSTR = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [2:0]            state, state_nx;
    logic                  owner;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic                  lat_we;
    logic                  lat_wide;
    logic [31:0]           lat_wdata;
    logic [15:0]           hi_q;
    logic [15:0]           instr_data;
    logic [31:0]           data_rdata;
    logic                  instr_valid_q;
    logic                  data_valid_q;
    logic [SW-1:0]         starve_cnt;

    logic                  any_req;
    logic                  starved;
    logic                  pick_data;
    logic [ADDR_WIDTH-1:0] addr_inc;

    assign any_req  = bus.instr_req_i | bus.data_req_i;
    assign starved  = (starve_cnt == LIMIT);
    assign addr_inc = lat_addr + ADDR_WIDTH'(1);

    // Fetch is forced through once data has won LIMIT times in a row while it waited.
    always_comb begin
        pick_data = 1'b0;
        if (bus.data_req_i && !bus.instr_req_i) begin
            pick_data = 1'b1;
        end else if (bus.data_req_i && bus.instr_req_i) begin
            pick_data = (DATA_PRIO != 0) && !starved;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    state_nx = (pick_data && bus.data_we_i) ? S_WR_A : S_RD_A;
                end
            end
            S_RD_A:    state_nx = lat_wide ? S_RD_B : S_RD_WAIT;
            S_RD_B:    state_nx = S_RD_WAIT;
            S_RD_WAIT: state_nx = S_IDLE;
            S_WR_A:    state_nx = lat_wide ? S_WR_B : S_IDLE;
            S_WR_B:    state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state         <= S_IDLE;
            owner         <= OWN_INSTR;
            lat_addr      <= '0;
            lat_we        <= 1'b0;
            lat_wide      <= 1'b0;
            lat_wdata     <= '0;
            hi_q          <= '0;
            instr_data    <= '0;
            data_rdata    <= '0;
            instr_valid_q <= 1'b0;
            data_valid_q  <= 1'b0;
            starve_cnt    <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE) begin
                starve_cnt <= (pick_data && bus.instr_req_i)
                              ? (starved ? starve_cnt : starve_cnt + SW'(1)) : '0;
                if (any_req) begin
                    owner     <= pick_data ? OWN_DATA : OWN_INSTR;
                    lat_addr  <= pick_data ? bus.data_addr_i : bus.instr_addr_i;
                    lat_we    <= pick_data & bus.data_we_i;
                    lat_wide  <= pick_data & bus.data_wide_i;
                    lat_wdata <= bus.data_wdata_i;
                end
            end
            // Memory returns data one cycle after the strobe, so RD_B sees the high word.
            if (state == S_RD_B) begin
                hi_q <= bus.mem_value_i;
            end
            if (state == S_RD_WAIT) begin
                if (owner == OWN_DATA) begin
                    data_rdata <= lat_wide ? {hi_q, bus.mem_value_i} : {16'h0000, bus.mem_value_i};
                end else begin
                    instr_data <= bus.mem_value_i;
                end
            end
            instr_valid_q <= (state == S_RD_WAIT) && (owner == OWN_INSTR);
            data_valid_q  <= ((state == S_RD_WAIT) && (owner == OWN_DATA))
                           || ((state == S_WR_A) && !lat_wide)
                           || (state == S_WR_B);
        end
    end

    always_comb begin
        bus.mem_addr_o  = '0;
        bus.mem_value_o = '0;
        case (state)
            S_RD_A: bus.mem_addr_o = lat_addr;
            S_RD_B: bus.mem_addr_o = addr_inc;
            S_WR_A: begin
                bus.mem_addr_o  = lat_addr;
                bus.mem_value_o = lat_wide ? lat_wdata[31:16] : lat_wdata[15:0];
            end
            S_WR_B: begin
                bus.mem_addr_o  = addr_inc;
                bus.mem_value_o = lat_wdata[15:0];
            end
            default: ;
        endcase
    end

    assign bus.mem_rd_en_o   = (state == S_RD_A) || (state == S_RD_B);
    assign bus.mem_wr_en_o   = (state == S_WR_A) || (state == S_WR_B);
    assign bus.mem_enable_o  = bus.mem_rd_en_o | bus.mem_wr_en_o;
    assign bus.instr_gnt_o   = (state == S_RD_A) && (owner == OWN_INSTR);
    assign bus.data_gnt_o    = ((state == S_RD_A) || (state == S_WR_A)) && (owner == OWN_DATA);
    assign bus.instr_valid_o = instr_valid_q;
    assign bus.data_valid_o  = data_valid_q;
    assign bus.instr_data_o  = instr_data;
    assign bus.data_rdata_o  = data_rdata;
    assign bus.busy_o        = (state != S_IDLE);

    logic unused_we;
    assign unused_we = lat_we;
endmodule
